// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: 6502 CPU port, DMA/loader port and the shared memory port.
// The arbiter binds the slave modport; the requesters and memory model bind master.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_rdy;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        grant_dma;
  logic        wr_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_rdy,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output grant_dma, wr_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_rdy,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  grant_dma, wr_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) single-memory arbiter with ROM write protection.
// Define ARB_STARVE_GUARD_EN to force a DMA grant after STARVE_LIMIT lost IDLE arbitrations.
module mem_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [3:0] ROM_BASE_NIB = 4'hF
) (
  input  logic          ph1,
  input  logic          reset_b,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_ACK, DMA_ACC, DMA_ACK} state_t;

  state_t      state, state_nxt;
  logic        armed;
  logic        rom_wr_q, rom_wr_nxt;
  logic [7:0]  cpu_rdata_q, dma_rdata_q;
  logic        pick_dma;

  logic        mem_en_c, mem_we_c, cpu_ack_c, dma_ack_c, grant_c, wr_err_c;
  logic [15:0] mem_addr_c;
  logic [7:0]  mem_wdata_c;

  function automatic logic is_rom(input logic [3:0] nib);
    return nib == ROM_BASE_NIB;
  endfunction

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt;

  assign pick_dma = (starve_cnt == LIMIT);

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b)
      starve_cnt <= '0;
    else if (state_nxt == DMA_ACC)
      starve_cnt <= '0;
    else if (state == IDLE && state_nxt == CPU_ACC && bus.dma_req && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + CW'(1);
  end
`else
  assign pick_dma = 1'b0;
`endif

  // armed holds off arbitration for the first edge after reset release
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      armed       <= 1'b0;
      rom_wr_q    <= 1'b0;
      cpu_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
    end else begin
      state    <= state_nxt;
      armed    <= 1'b1;
      rom_wr_q <= rom_wr_nxt;
      if (state == CPU_ACK) cpu_rdata_q <= bus.mem_rdata;
      if (state == DMA_ACK) dma_rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = 16'h0000;
    mem_wdata_c = 8'h00;
    cpu_ack_c   = 1'b0;
    dma_ack_c   = 1'b0;
    grant_c     = 1'b0;
    wr_err_c    = 1'b0;
    rom_wr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (armed) begin
          if (bus.cpu_req && !(bus.dma_req && pick_dma)) state_nxt = CPU_ACC;
          else if (bus.dma_req)                          state_nxt = DMA_ACC;
        end
      end
      CPU_ACC: begin
        state_nxt   = CPU_ACK;
        mem_en_c    = 1'b1;
        mem_addr_c  = bus.cpu_addr;
        mem_wdata_c = bus.cpu_wdata;
        mem_we_c    = bus.cpu_we && !is_rom(bus.cpu_addr[15:12]);
        rom_wr_nxt  = bus.cpu_we &&  is_rom(bus.cpu_addr[15:12]);
      end
      CPU_ACK: begin
        state_nxt = bus.dma_req ? DMA_ACC : IDLE;
        cpu_ack_c = 1'b1;
        wr_err_c  = rom_wr_q;
      end
      DMA_ACC: begin
        state_nxt   = DMA_ACK;
        grant_c     = 1'b1;
        mem_en_c    = 1'b1;
        mem_addr_c  = bus.dma_addr;
        mem_wdata_c = bus.dma_wdata;
        mem_we_c    = bus.dma_we && !is_rom(bus.dma_addr[15:12]);
        rom_wr_nxt  = bus.dma_we &&  is_rom(bus.dma_addr[15:12]);
      end
      DMA_ACK: begin
        state_nxt = bus.cpu_req ? CPU_ACC : IDLE;
        grant_c   = 1'b1;
        dma_ack_c = 1'b1;
        wr_err_c  = rom_wr_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.cpu_ack   = cpu_ack_c;
  assign bus.dma_ack   = dma_ack_c;
  assign bus.grant_dma = grant_c;
  assign bus.wr_err    = wr_err_c;
  // Read data passes straight through in the ack cycle, then holds
  assign bus.cpu_rdata = (state == CPU_ACK) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dma_rdata = (state == DMA_ACK) ? bus.mem_rdata : dma_rdata_q;
  assign bus.cpu_rdy   = !(bus.cpu_req && !cpu_ack_c);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized two-port run
// scored against a transaction-level memory model.
module tb_mem_arbiter;
  localparam logic [3:0] ROM_NIB = 4'hF;
`ifdef ARB_STARVE_GUARD_EN
  localparam int EXP_LOSSES = 4;
`else
  localparam int EXP_LOSSES = 8;
`endif

  logic ph1 = 1'b0;
  logic reset_b = 1'b0;
  always #5 ph1 = ~ph1;

  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_LIMIT(4), .ROM_BASE_NIB(ROM_NIB)) dut (.ph1(ph1), .reset_b(reset_b), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Memory device: read data valid one cycle after mem_en
  bit [7:0] mem_val [0:65535];
  bit       mem_vld [0:65535];
  logic [7:0] mem_rd_q = 8'h00;
  assign bus.mem_rdata = mem_rd_q;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(posedge ph1) begin
    if (bus.mem_en) begin
      mem_rd_q <= mem_vld[bus.mem_addr] ? mem_val[bus.mem_addr] : pat(bus.mem_addr);
      if (bus.mem_we) begin
        mem_val[bus.mem_addr] <= bus.mem_wdata;
        mem_vld[bus.mem_addr] <= 1'b1;
      end
    end
  end

  // Reference: contents the memory should hold, by the order accesses complete
  logic [7:0] sh_val [int];

  function automatic logic is_rom(input logic [15:0] a);
    return a[15:12] == ROM_NIB;
  endfunction

  function automatic logic [7:0] exp_mem(input logic [15:0] a);
    return sh_val.exists(int'(a)) ? sh_val[int'(a)] : pat(a);
  endfunction

  task automatic drive_port(input bit dma, input bit req, input bit we, input logic [15:0] a, input logic [7:0] d);
    if (dma) begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    drive_port(0, 0, 0, 16'h0, 8'h0);
    drive_port(1, 0, 0, 16'h0, 8'h0);
    repeat (2) @(negedge ph1);
    reset_b = 1'b1;
    @(negedge ph1);
  endtask

  // Results of the last single directed access
  logic [7:0]  r_rd;
  int          r_lat, r_en_cyc, r_err_cnt;
  logic        r_we, r_grant, r_err_ack, r_got;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;

  task automatic port_access(input bit dma, input bit we, input logic [15:0] a, input logic [7:0] d);
    int cyc;
    drive_port(dma, 1, we, a, d);
    cyc = 1; r_got = 0; r_en_cyc = 0; r_err_cnt = 0; r_lat = 0;
    r_we = 0; r_grant = 0; r_addr = 16'h0; r_wdata = 8'h0; r_err_ack = 0; r_rd = 8'h0;
    while (!r_got && cyc < 20) begin
      @(negedge ph1);
      cyc++;
      r_err_cnt += int'(bus.wr_err);
      if (bus.mem_en && r_en_cyc == 0) begin
        r_en_cyc = cyc; r_we = bus.mem_we; r_addr = bus.mem_addr;
        r_wdata = bus.mem_wdata; r_grant = bus.grant_dma;
      end
      if (dma ? bus.dma_ack : bus.cpu_ack) begin
        r_got = 1; r_lat = cyc; r_err_ack = bus.wr_err;
        r_rd = dma ? bus.dma_rdata : bus.cpu_rdata;
      end
    end
    n_checks++; if (!r_got) $display("FAIL ack_timeout: got no ack, required ack within 20 cycles"); else n_pass++;
    if (r_got && we && !is_rom(a)) sh_val[int'(a)] = d;
    drive_port(dma, 0, 0, 16'h0, 8'h0);
    @(negedge ph1);
    r_err_cnt += int'(bus.wr_err);
  endtask

  task automatic test_reset();
    bus.cpu_req = 1'b1;
    repeat (2) @(negedge ph1);
    n_checks++; if (bus.mem_en !== 1'b0)       $display("FAIL rst_mem_en: got %b required 0", bus.mem_en); else n_pass++;
    n_checks++; if (bus.mem_we !== 1'b0)       $display("FAIL rst_mem_we: got %b required 0", bus.mem_we); else n_pass++;
    n_checks++; if (bus.mem_addr !== 16'h0)    $display("FAIL rst_mem_addr: got %h required 0000", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.cpu_ack !== 1'b0 || bus.dma_ack !== 1'b0) $display("FAIL rst_ack: got %b%b required 00", bus.cpu_ack, bus.dma_ack); else n_pass++;
    n_checks++; if (bus.grant_dma !== 1'b0 || bus.wr_err !== 1'b0) $display("FAIL rst_grant_err: got %b%b required 00", bus.grant_dma, bus.wr_err); else n_pass++;
    n_checks++; if (bus.cpu_rdata !== 8'h00 || bus.dma_rdata !== 8'h00) $display("FAIL rst_rdata: got %h/%h required 00/00", bus.cpu_rdata, bus.dma_rdata); else n_pass++;
    n_checks++; if (bus.cpu_rdy !== 1'b0)      $display("FAIL rst_rdy_req: got %b required 0", bus.cpu_rdy); else n_pass++;
    bus.cpu_req = 1'b0; #1;
    n_checks++; if (bus.cpu_rdy !== 1'b1)      $display("FAIL rst_rdy_idle: got %b required 1", bus.cpu_rdy); else n_pass++;
    // Request already waiting when reset releases: no grant on the first edge
    drive_port(0, 1, 0, 16'h0123, 8'h00);
    reset_b = 1'b1;
    @(negedge ph1);
    n_checks++; if (bus.mem_en !== 1'b0)       $display("FAIL first_edge_grant: got mem_en %b required 0", bus.mem_en); else n_pass++;
    @(negedge ph1);
    n_checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0123) $display("FAIL second_edge_grant: got en %b addr %h required 1 0123", bus.mem_en, bus.mem_addr); else n_pass++;
    @(negedge ph1);
    n_checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== pat(16'h0123)) $display("FAIL first_read: got ack %b data %h required 1 %h", bus.cpu_ack, bus.cpu_rdata, pat(16'h0123)); else n_pass++;
    drive_port(0, 0, 0, 16'h0, 8'h0);
    @(negedge ph1);
    n_checks++; if (bus.cpu_rdata !== pat(16'h0123)) $display("FAIL rdata_hold: got %h required %h", bus.cpu_rdata, pat(16'h0123)); else n_pass++;
  endtask

  task automatic test_cpu_write_read();
    port_access(0, 1, 16'h022A, 8'h55);
    n_checks++; if (r_lat !== 3 || r_en_cyc !== 2) $display("FAIL wr_latency: got en %0d ack %0d required 2 3", r_en_cyc, r_lat); else n_pass++;
    n_checks++; if (r_we !== 1'b1 || r_addr !== 16'h022A || r_wdata !== 8'h55) $display("FAIL wr_bus: got we %b addr %h data %h required 1 022A 55", r_we, r_addr, r_wdata); else n_pass++;
    n_checks++; if (r_err_cnt !== 0 || r_grant !== 1'b0) $display("FAIL wr_side: got err %0d grant %b required 0 0", r_err_cnt, r_grant); else n_pass++;
    port_access(0, 0, 16'h022A, 8'h00);
    n_checks++; if (r_lat !== 3 || r_we !== 1'b0) $display("FAIL rd_latency: got ack %0d we %b required 3 0", r_lat, r_we); else n_pass++;
    n_checks++; if (r_rd !== 8'h55) $display("FAIL rd_data: got %h required 55", r_rd); else n_pass++;
  endtask

  task automatic test_rom_write();
    port_access(1, 1, 16'hFFFD, 8'hF0);
    n_checks++; if (r_en_cyc !== 2 || r_we !== 1'b0) $display("FAIL rom_we: got en_cyc %0d we %b required 2 0", r_en_cyc, r_we); else n_pass++;
    n_checks++; if (r_grant !== 1'b1) $display("FAIL rom_grant: got %b required 1", r_grant); else n_pass++;
    n_checks++; if (r_err_ack !== 1'b1 || r_err_cnt !== 1) $display("FAIL rom_wr_err: got at_ack %b pulses %0d required 1 1", r_err_ack, r_err_cnt); else n_pass++;
    n_checks++; if (mem_vld[16'hFFFD] !== 1'b0) $display("FAIL rom_unchanged: got written %b required 0", mem_vld[16'hFFFD]); else n_pass++;
    port_access(1, 0, 16'hFFFD, 8'h00);
    n_checks++; if (r_rd !== pat(16'hFFFD) || r_err_cnt !== 0) $display("FAIL rom_read: got %h err %0d required %h 0", r_rd, r_err_cnt, pat(16'hFFFD)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ngrant;
    do_reset();
    drive_port(0, 1, 0, 16'h0010, 8'h00);
    drive_port(1, 1, 0, 16'h0020, 8'h00);
    ngrant = 0;
    for (int k = 1; k <= 16 && ngrant < 4; k++) begin
      @(negedge ph1);
      n_checks++; if (bus.cpu_rdy !== bus.cpu_ack) $display("FAIL b2b_rdy: cycle %0d got %b required %b", k, bus.cpu_rdy, bus.cpu_ack); else n_pass++;
      if (bus.mem_en) begin
        n_checks++;
        if (k !== 1 + 2 * ngrant || bus.grant_dma !== logic'(ngrant % 2))
          $display("FAIL b2b_grant: grant %0d at cycle %0d dma %b required cycle %0d dma %0d", ngrant, k, bus.grant_dma, 1 + 2 * ngrant, ngrant % 2);
        else n_pass++;
        ngrant++;
      end
    end
    n_checks++; if (ngrant !== 4) $display("FAIL b2b_count: got %0d grants required 4", ngrant); else n_pass++;
    drive_port(0, 0, 0, 16'h0, 8'h0);
    drive_port(1, 0, 0, 16'h0, 8'h0);
    repeat (3) @(negedge ph1);
  endtask

  task automatic test_starve();
    int losses;
    bit won, stuck;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      losses = 0; won = 0; stuck = 0;
      for (int r = 0; r < 8 && !won && !stuck; r++) begin
        drive_port(0, 1, 0, 16'h0100, 8'h00);
        drive_port(1, 1, 0, 16'h0200, 8'h00);
        @(negedge ph1);
        if (bus.mem_en && bus.grant_dma) won = 1;
        else if (bus.mem_en) begin
          losses++;
          bus.dma_req = 1'b0;
          @(negedge ph1);
          bus.cpu_req = 1'b0;
          @(negedge ph1);
        end else stuck = 1;
      end
      n_checks++; if (stuck) $display("FAIL starve_nogrant: phase %0d got no grant, required one", p); else n_pass++;
      if (won) begin
        bus.cpu_req = 1'b0;
        @(negedge ph1);
        bus.dma_req = 1'b0;
        @(negedge ph1);
      end
      n_checks++; if (losses !== EXP_LOSSES || won !== (EXP_LOSSES == 4)) $display("FAIL starve_guard: phase %0d got losses %0d dma %b required %0d %b", p, losses, won, EXP_LOSSES, EXP_LOSSES == 4); else n_pass++;
    end
    drive_port(0, 0, 0, 16'h0, 8'h0);
    drive_port(1, 0, 0, 16'h0, 8'h0);
    @(negedge ph1);
  endtask

  task automatic test_reset_mid();
    int acks, ack_cyc;
    port_access(0, 0, 16'h022A, 8'h00);
    n_checks++; if (r_rd !== 8'h55) $display("FAIL pre_reset_read: got %h required 55", r_rd); else n_pass++;
    drive_port(0, 1, 0, 16'h022A, 8'h00);
    @(negedge ph1);
    n_checks++; if (bus.mem_en !== 1'b1) $display("FAIL mid_acc: got mem_en %b required 1", bus.mem_en); else n_pass++;
    #2 reset_b = 1'b0;
    #1;
    n_checks++; if ({bus.mem_en, bus.cpu_ack, bus.grant_dma, bus.cpu_rdata} !== 11'h0) $display("FAIL mid_reset_outs: got en %b ack %b grant %b rdata %h required all 0", bus.mem_en, bus.cpu_ack, bus.grant_dma, bus.cpu_rdata); else n_pass++;
    acks = 0;
    repeat (3) begin @(negedge ph1); acks += int'(bus.cpu_ack); end
    n_checks++; if (acks !== 0) $display("FAIL mid_reset_ack: got %0d acks required 0", acks); else n_pass++;
    reset_b = 1'b1;
    ack_cyc = 0;
    for (int c = 1; c <= 10 && ack_cyc == 0; c++) begin
      @(negedge ph1);
      if (bus.cpu_ack) begin
        ack_cyc = c;
        n_checks++; if (bus.cpu_rdata !== 8'h55) $display("FAIL reissue_data: got %h required 55", bus.cpu_rdata); else n_pass++;
      end
    end
    n_checks++; if (ack_cyc !== 3) $display("FAIL reissue_ack: got cycle %0d required 3", ack_cyc); else n_pass++;
    drive_port(0, 0, 0, 16'h0, 8'h0);
    @(negedge ph1);
  endtask

  int done_cnt;

  function automatic logic [15:0] pick_addr();
    logic [3:0] nib;
    case ($urandom_range(0, 2))
      0: nib = 4'h0;
      1: nib = 4'h3;
      default: nib = ROM_NIB;
    endcase
    return {nib, 9'h000, 3'($urandom_range(0, 7))};
  endfunction

  task automatic run_port(input bit dma);
    bit we, got;
    logic [15:0] a;
    logic [7:0] d, rd;
    for (int t = 0; t < 50; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge ph1);
      we = 1'($urandom_range(0, 1)); a = pick_addr(); d = 8'($urandom);
      drive_port(dma, 1, we, a, d);
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge ph1);
        if (dma ? bus.dma_ack : bus.cpu_ack) got = 1;
      end
      n_checks++; if (!got) $display("FAIL rand_timeout: port %0d got no ack required ack within 40", dma); else n_pass++;
      if (got) begin
        rd = dma ? bus.dma_rdata : bus.cpu_rdata;
        if (!we) begin
          n_checks++; if (rd !== exp_mem(a)) $display("FAIL rand_rdata: port %0d addr %h got %h required %h", dma, a, rd, exp_mem(a)); else n_pass++;
        end
        n_checks++; if (bus.wr_err !== (we && is_rom(a))) $display("FAIL rand_wr_err: port %0d addr %h got %b required %b", dma, a, bus.wr_err, we && is_rom(a)); else n_pass++;
        if (we && !is_rom(a)) sh_val[int'(a)] = d;
      end
      drive_port(dma, 0, 0, 16'h0, 8'h0);
    end
    done_cnt++;
  endtask

  task automatic run_monitor();
    logic [7:0] last_cpu, last_dma;
    last_cpu = bus.cpu_rdata; last_dma = bus.dma_rdata;
    for (int c = 0; c < 6000 && done_cnt < 2; c++) begin
      @(posedge ph1); #2;
      n_checks++; if (bus.cpu_rdy !== !(bus.cpu_req && !bus.cpu_ack)) $display("FAIL mon_rdy: got %b req %b ack %b", bus.cpu_rdy, bus.cpu_req, bus.cpu_ack); else n_pass++;
      n_checks++; if (bus.cpu_ack && bus.dma_ack) $display("FAIL mon_two_acks: got both acks required at most one"); else n_pass++;
      n_checks++; if (bus.mem_we && (!bus.mem_en || is_rom(bus.mem_addr))) $display("FAIL mon_mem_we: got we 1 en %b addr %h required no write", bus.mem_en, bus.mem_addr); else n_pass++;
      n_checks++; if (bus.wr_err && !(bus.cpu_ack || bus.dma_ack)) $display("FAIL mon_wr_err: got wr_err outside ack cycle required 0"); else n_pass++;
      if (bus.cpu_ack) last_cpu = bus.cpu_rdata;
      else begin n_checks++; if (bus.cpu_rdata !== last_cpu) $display("FAIL mon_cpu_hold: got %h required %h", bus.cpu_rdata, last_cpu); else n_pass++; end
      if (bus.dma_ack) last_dma = bus.dma_rdata;
      else begin n_checks++; if (bus.dma_rdata !== last_dma) $display("FAIL mon_dma_hold: got %h required %h", bus.dma_rdata, last_dma); else n_pass++; end
    end
    n_checks++; if (done_cnt < 2) $display("FAIL rand_finish: got %0d ports done required 2", done_cnt); else n_pass++;
  endtask

  task automatic test_random();
    done_cnt = 0;
    fork
      run_port(0);
      run_port(1);
      run_monitor();
    join
    repeat (3) @(negedge ph1);
  endtask

  initial begin
    drive_port(0, 0, 0, 16'h0, 8'h0);
    drive_port(1, 0, 0, 16'h0, 8'h0);
    test_reset();
    test_cpu_write_read();
    test_rom_write();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
